sipo_word_collector: RTL and testbench
======================================

Name: sipo_word_collector

Overview:
- Downstream consumer of the 8-bit shift register stage: samples its serial output bit, one bit per qualified clock.
- Assembles WIDTH-bit words and presents each through a registered valid/ready output with a one-word holding register.
- Provides framing resync, sticky overflow detection and a delivered-word counter for bench and system observation.

Parameters:
- WIDTH, 8, bits per assembled word (>=2).
- MSB_FIRST, 1, 1: first received bit lands in par_out[WIDTH-1]; 0: first received bit lands in par_out[0].
- CNT_W, 8, width of word_cnt.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is sampled at this edge.
- sync  input  1  discard partial word, restart framing.
- par_ready  input  1  consumer accepts par_out.
- clr_ovf  input  1  clears overflow.
- par_out  output  WIDTH  assembled word (registered).
- par_valid  output  1  par_out holds an unaccepted word.
- overflow  output  1  sticky: a completed word was dropped.
- bit_cnt  output  $clog2(WIDTH)  bits collected in current partial word.
- word_cnt  output  CNT_W  count of accepted words, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rstn low, asynchronous): shreg=0, bit_cnt=0, par_out=0, par_valid=0, overflow=0, word_cnt=0. Held while low; first capture on the first edge after release.
- Shift, when ser_valid=1 and sync=0:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: shreg <= {ser_in, shreg[WIDTH-1:1]}.
  - bit_cnt increments.
- Completion: the edge sampling the WIDTH-th bit (bit_cnt==WIDTH-1 and ser_valid=1) is the completing edge.
  - bit_cnt returns to 0.
  - The assembled word is the shifted value including this bit.
  - Latency: par_valid visible in the cycle after the completing edge. No bubble: bits may arrive every cycle.
- Output FSM, two states:
  - EMPTY (par_valid=0): on completion load par_out and go to FULL.
  - FULL (par_valid=1): par_out stays stable.
    - par_ready=1 at an edge with no completion: go to EMPTY, word_cnt+1.
    - par_ready=1 and completion at the same edge: load new word, stay FULL, word_cnt+1.
    - par_ready=0 and completion: new word dropped, old word kept, overflow set.
- Handshake rules:
  - Transfer occurs only at an edge where par_valid=1 and par_ready=1.
  - par_ready while EMPTY has no effect.
  - par_valid never depends combinationally on par_ready.
- sync=1 at an edge: shreg cleared, bit_cnt=0, any ser_valid bit at that edge discarded (sync wins). The output register, par_valid, overflow and word_cnt are unaffected.
- overflow: set on a dropped word, cleared by clr_ovf. If set and clear occur at the same edge, set wins.
- word_cnt wraps from 2^CNT_W-1 to 0 silently.
- ser_valid=0: shreg and bit_cnt hold. Gaps of any length are legal mid-word.

Decomposition:
- Shared package/header holds:
  - default WIDTH (8) and CNT_W (8);
  - bit-order encodings MSB_FIRST=1 and LSB_FIRST=0;
  - output-FSM state encodings EMPTY=0 and FULL=1.
- One sub-module, sipo_shifter:
  - Contains shreg and bit_cnt; owns shift direction, sync clear and reset.
  - Outputs word_done (completing edge) and the next-word value.
  - The top level contains the output register, FSM, overflow and word_cnt.

Test Plan:
- Basic shift, MSB_FIRST=1: par_ready=1, 8 consecutive ser_valid bits 1,0,1,0,1,0,1,0 -> par_out=8'hAA, par_valid=1 for one cycle after the 8th edge, then word_cnt=1.
- Bit order, MSB_FIRST=0: send the same bit sequence -> par_out=8'h55.
- Backpressure:
  - par_ready=0, send 8'hAA then 8'hF0 (MSB first) -> par_out stays 8'hAA, overflow=1.
  - Then raise par_ready -> word_cnt=1, par_valid=0.
  - Then pulse clr_ovf -> overflow=0.
- Simultaneous completion and accept: word 8'h0F held, par_ready=1 on the edge that completes 8'h3C -> par_out=8'h3C, par_valid stays 1, overflow=0, word_cnt+1.
- Sync mid-word:
  - After 5 bits, pulse sync together with ser_valid=1 -> bit_cnt=0.
  - Then 8 bits 11001100 -> par_out=8'hCC.
- Reset mid-operation:
  - Assert rstn low between edges with 3 bits collected and par_valid=1 -> all outputs 0 immediately.
  - After release, 8 bits 10101010 -> par_out=8'hAA.

Source files
------------

// File: rtl/sipo_word_collector_pkg.sv
// Shared defaults and encodings for the serial-to-parallel word collector.
// Holds the bit-order codes and the output holding-register state type.
package sipo_word_collector_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 8;

  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/sipo_shifter.sv
// Serial shift register with bit counter and framing resync.
// Flags the completing edge and exposes the word value that edge produces.
module sipo_shifter
  import sipo_word_collector_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  input  logic                     sync,
  output logic                     word_done,
  output logic [WIDTH-1:0]         word_next,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    cnt_q, cnt_d;

  generate
    if (MSB_FIRST == ORDER_MSB_FIRST) begin : g_msb
      assign word_next = {shreg_q[WIDTH-2:0], ser_in};
    end else begin : g_lsb
      assign word_next = {ser_in, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  // sync overrides a bit arriving on the same edge
  assign word_done = ser_valid && !sync && (cnt_q == LAST);
  assign bit_cnt   = cnt_q;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (sync) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (ser_valid) begin
      shreg_d = word_next;
      cnt_d   = word_done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_word_collector.sv
// Collects serial bits into words and offers them through a one-word
// valid/ready holding register with sticky overflow and delivered-word count.
module sipo_word_collector
  import sipo_word_collector_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  input  logic                     sync,
  input  logic                     par_ready,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         par_out,
  output logic                     par_valid,
  output logic                     overflow,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic [CNT_W-1:0]         word_cnt
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic             word_done;
  logic [WIDTH-1:0] word_next;
  logic             accept, load, drop;

  sipo_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .sync      (sync),
    .word_done (word_done),
    .word_next (word_next),
    .bit_cnt   (bit_cnt)
  );

  assign accept = (state_q == ST_FULL) && par_ready;
  assign load   = word_done && ((state_q == ST_EMPTY) || par_ready);
  assign drop   = word_done && (state_q == ST_FULL) && !par_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (word_done) state_d = ST_FULL;
      ST_FULL:  if (par_ready && !word_done) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    par_valid = (state_q == ST_FULL);
  end

  // A dropped word sets overflow even if a clear arrives on the same edge
  always_comb begin
    par_out_d  = load ? word_next : par_out_q;
    word_cnt_d = accept ? word_cnt_q + 1'b1 : word_cnt_q;
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_out_q  <= '0;
      overflow_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      par_out_q  <= par_out_d;
      overflow_q <= overflow_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign par_out  = par_out_q;
  assign overflow = overflow_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_sipo_word_collector.sv
// Bench for the word collector: MSB-first and LSB-first instances share one
// stimulus stream and are compared against a bit-queue reference model.
module tb_sipo_word_collector;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rstn, ser_in, ser_valid, sync, par_ready, clr_ovf;

  logic [W-1:0] pout_m, pout_l;
  logic         pval_m, pval_l, ovf_m, ovf_l;
  logic [2:0]   bcnt_m, bcnt_l;
  logic [7:0]   wcnt_m, wcnt_l;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         bits[$];
  logic [7:0] m_word_msb, m_word_lsb, m_cnt;
  logic       m_valid, m_ovf;

  always #5 clk = ~clk;

  sipo_word_collector #(.WIDTH(W), .MSB_FIRST(1'b1), .CNT_W(8)) u_msb (
    .clk(clk), .rstn(rstn), .ser_in(ser_in), .ser_valid(ser_valid), .sync(sync),
    .par_ready(par_ready), .clr_ovf(clr_ovf), .par_out(pout_m), .par_valid(pval_m),
    .overflow(ovf_m), .bit_cnt(bcnt_m), .word_cnt(wcnt_m)
  );

  sipo_word_collector #(.WIDTH(W), .MSB_FIRST(1'b0), .CNT_W(8)) u_lsb (
    .clk(clk), .rstn(rstn), .ser_in(ser_in), .ser_valid(ser_valid), .sync(sync),
    .par_ready(par_ready), .clr_ovf(clr_ovf), .par_out(pout_l), .par_valid(pval_l),
    .overflow(ovf_l), .bit_cnt(bcnt_l), .word_cnt(wcnt_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    m_word_msb = '0;
    m_word_lsb = '0;
    m_cnt      = '0;
    m_valid    = 1'b0;
    m_ovf      = 1'b0;
  endtask

  // One clock edge of the specified behaviour, from the inputs held at that edge
  task automatic model_step();
    bit         done;
    bit         dropped;
    logic [7:0] wm, wl;
    done = 0;
    dropped = 0;
    wm = '0;
    wl = '0;
    if (sync) bits.delete();
    else if (ser_valid) begin
      bits.push_back(ser_in);
      if (bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm = wm | (8'(bits[i]) << (W - 1 - i));
          wl = wl | (8'(bits[i]) << i);
        end
        bits.delete();
        done = 1;
      end
    end
    if (m_valid && par_ready) begin
      m_cnt = m_cnt + 8'd1;
      if (done) begin m_word_msb = wm; m_word_lsb = wl; end
      else m_valid = 1'b0;
    end else if (m_valid && done) begin
      dropped = 1;
    end else if (done) begin
      m_word_msb = wm;
      m_word_lsb = wl;
      m_valid = 1'b1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic check_all();
    chk("par_out_msb", 32'(pout_m), 32'(m_word_msb));
    chk("par_out_lsb", 32'(pout_l), 32'(m_word_lsb));
    chk("par_valid", 32'(pval_m), 32'(m_valid));
    chk("par_valid_lsb", 32'(pval_l), 32'(m_valid));
    chk("overflow", 32'(ovf_m), 32'(m_ovf));
    chk("overflow_lsb", 32'(ovf_l), 32'(m_ovf));
    chk("bit_cnt", 32'(bcnt_m), 32'(bits.size()));
    chk("bit_cnt_lsb", 32'(bcnt_l), 32'(bits.size()));
    chk("word_cnt", 32'(wcnt_m), 32'(m_cnt));
    chk("word_cnt_lsb", 32'(wcnt_l), 32'(m_cnt));
  endtask

  task automatic cyc(input logic sv, input logic si, input logic sy,
                     input logic rdy, input logic clr);
    ser_valid = sv;
    ser_in    = si;
    sync      = sy;
    par_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Sends w MSB first; ready is rdy for the first 7 bits and rdy_last on the 8th
  task automatic send_word(input logic [7:0] w, input logic rdy, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--)
      cyc(1'b1, w[i], 1'b0, (i == 0) ? rdy_last : rdy, 1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    ser_in = 1'b0; ser_valid = 1'b0; sync = 1'b0; par_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rstn = 1'b1;

    // basic shift with ready high: AA for MSB-first, 55 for LSB-first
    send_word(8'hAA, 1'b1, 1'b1);
    chk("basic_msb_aa", 32'(pout_m), 32'h AA);
    chk("basic_lsb_55", 32'(pout_l), 32'h 55);
    chk("basic_valid", 32'(pval_m), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_cnt1", 32'(wcnt_m), 32'd1);
    chk("basic_valid0", 32'(pval_m), 32'd0);

    // backpressure: second word dropped, overflow sticky until cleared
    send_word(8'hAA, 1'b0, 1'b0);
    send_word(8'hF0, 1'b0, 1'b0);
    chk("bp_hold_aa", 32'(pout_m), 32'h AA);
    chk("bp_ovf", 32'(ovf_m), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_cnt", 32'(wcnt_m), 32'd2);
    chk("bp_valid0", 32'(pval_m), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_clr", 32'(ovf_m), 32'd0);

    // accept and completion on the same edge
    send_word(8'h0F, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b1);
    chk("simul_3c", 32'(pout_m), 32'h 3C);
    chk("simul_valid", 32'(pval_m), 32'd1);
    chk("simul_ovf", 32'(ovf_m), 32'd0);
    chk("simul_cnt", 32'(wcnt_m), 32'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // sync mid-word discards the partial word and the bit on the sync edge
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sync_bitcnt", 32'(bcnt_m), 32'd0);
    send_word(8'hCC, 1'b0, 1'b0);
    chk("sync_cc", 32'(pout_m), 32'h CC);

    // overflow set and clear on the same edge: set wins
    send_word(8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(ovf_m), 32'd1);

    // asynchronous reset between edges with a word held and 3 bits pending
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rstn = 1'b1;
    send_word(8'hAA, 1'b0, 1'b0);
    chk("rst_aa", 32'(pout_m), 32'h AA);

    // randomized traffic, long enough for word_cnt to wrap
    for (int n = 0; n < 3000; n++)
      cyc(($urandom_range(99) < 85) ? 1'b1 : 1'b0, 1'($urandom),
          ($urandom_range(99) < 2) ? 1'b1 : 1'b0,
          ($urandom_range(99) < 75) ? 1'b1 : 1'b0,
          ($urandom_range(99) < 5) ? 1'b1 : 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
